sipo: RTL and testbench

//  - Serial-in, parallel-out shift register. Captures one serial bit per clock
//    and presents the last WIDTH bits on a parallel bus.
//  - Leaf datapath block for deserialising slow serial links (UART or SPI-like

---
 rtl/sipo_pkg.sv | 15 +
 rtl/sipo_if.sv | 31 +++
 rtl/sipo_bit_counter.sv | 39 +++
 rtl/sipo.sv | 51 +++++
 tb/tb_sipo.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// Shared defaults and sizing helper for the serial-in, parallel-out shifter.
package sipo_pkg;

  localparam int SIPO_DEF_WIDTH     = 4;
  localparam int SIPO_DEF_MSB_FIRST = 1;

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_if.sv
// Parallel-side bundle of the sipo block; word_valid exists only with SIPO_WORD_VALID_EN.
// There is no valid/ready handshake: din is taken on every rising edge and dout always reflects the last WIDTH samples.
interface sipo_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEF_WIDTH
);

  logic             din;
  logic [WIDTH-1:0] dout;
`ifdef SIPO_WORD_VALID_EN
  logic             word_valid;
`endif

  modport master (
    output din,
`ifdef SIPO_WORD_VALID_EN
    input  word_valid,
`endif
    input  dout
  );

  modport slave (
    input  din,
`ifdef SIPO_WORD_VALID_EN
    output word_valid,
`endif
    output dout
  );

endinterface

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter with a registered pulse in the cycle after each wrap.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  output logic wrap_o
);

  localparam int             CW   = clog2_min1(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    wrap_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap_o = wrap_q;

endmodule

// File: rtl/sipo.sv
// Serial-in, parallel-out shift register; shifts on every rising edge, async active-high reset.
// Define SIPO_WORD_VALID_EN to add the word_valid output and its bit counter.
module sipo
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_DEF_WIDTH,
  parameter int MSB_FIRST = SIPO_DEF_MSB_FIRST
) (
  input  logic             din,
  input  logic             clk,
  input  logic             reset,
`ifdef SIPO_WORD_VALID_EN
  output logic [WIDTH-1:0] dout,
  output logic             word_valid
`else
  output logic [WIDTH-1:0] dout
`endif
);

  logic [WIDTH-1:0] dout_q, dout_d;

  // Direction only changes which end the new bit enters; older bits slide away from it.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign dout_d = {dout_q[WIDTH-2:0], din};
    end else begin : g_lsb_first
      assign dout_d = {din, dout_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef SIPO_WORD_VALID_EN
  sipo_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (reset),
    .wrap_o (word_valid)
  );
`endif

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: WIDTH=4 MSB/LSB-first and WIDTH=8 MSB-first side by side.
module tb_sipo;
  import sipo_pkg::*;

  logic clk;
  logic reset;
  logic din;

  sipo_if #(.WIDTH(4)) bus4m ();
  sipo_if #(.WIDTH(4)) bus4l ();
  sipo_if #(.WIDTH(8)) bus8  ();

  assign bus4m.din = din;
  assign bus4l.din = din;
  assign bus8.din  = din;

  sipo #(.WIDTH(4), .MSB_FIRST(1)) dut4m (
    .din        (bus4m.din),
    .clk        (clk),
    .reset      (reset),
`ifdef SIPO_WORD_VALID_EN
    .word_valid (bus4m.word_valid),
`endif
    .dout       (bus4m.dout)
  );

  sipo #(.WIDTH(4), .MSB_FIRST(0)) dut4l (
    .din        (bus4l.din),
    .clk        (clk),
    .reset      (reset),
`ifdef SIPO_WORD_VALID_EN
    .word_valid (bus4l.word_valid),
`endif
    .dout       (bus4l.dout)
  );

  sipo #(.WIDTH(8), .MSB_FIRST(1)) dut8 (
    .din        (bus8.din),
    .clk        (clk),
    .reset      (reset),
`ifdef SIPO_WORD_VALID_EN
    .word_valid (bus8.word_valid),
`endif
    .dout       (bus8.dout)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks;
  int errors;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of samples since reset, newest first.
  bit hist[$];
  int nsh;

  task automatic model_reset();
    hist.delete();
    nsh = 0;
  endtask

  function automatic logic [7:0] model_dout(input int w, input bit msb);
    logic [7:0] e;
    bit         b;
    e = '0;
    for (int k = 0; k < w; k++) begin
      b = (k < hist.size()) ? hist[k] : 1'b0;
      if (msb) e[k] = b;
      else     e[w-1-k] = b;
    end
    return e;
  endfunction

  task automatic check_all();
    logic [7:0] exp_q[$];
    exp_q.push_back(model_dout(4, 1'b1));
    exp_q.push_back(model_dout(4, 1'b0));
    exp_q.push_back(model_dout(8, 1'b1));
    check("model_4m", {4'b0, bus4m.dout}, exp_q.pop_front());
    check("model_4l", {4'b0, bus4l.dout}, exp_q.pop_front());
    check("model_8",  bus8.dout,          exp_q.pop_front());
`ifdef SIPO_WORD_VALID_EN
    check("wv_4m", {7'b0, bus4m.word_valid}, {7'b0, (nsh > 0) && (nsh % 4 == 0)});
    check("wv_4l", {7'b0, bus4l.word_valid}, {7'b0, (nsh > 0) && (nsh % 4 == 0)});
    check("wv_8",  {7'b0, bus8.word_valid},  {7'b0, (nsh > 0) && (nsh % 8 == 0)});
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic drive_bit(input bit b);
    din = b;
    @(posedge clk);
    hist.push_front(b);
    if (hist.size() > 8) void'(hist.pop_back());
    nsh++;
    @(negedge clk);
    check_all();
  endtask

  // Pulse reset between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_4m", {4'b0, bus4m.dout}, 8'h00);
    check("async_rst_8",  bus8.dout,          8'h00);
`ifdef SIPO_WORD_VALID_EN
    check("async_rst_wv", {7'b0, bus4m.word_valid}, 8'h00);
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit         din;
    logic [3:0] exp_m;
    logic [3:0] exp_l;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] pat;
    logic [7:0] wv_seen;
    checks = 0;
    errors = 0;
    model_reset();

    vecs[0] = '{1'b1, 4'b0001, 4'b1000};
    vecs[1] = '{1'b1, 4'b0011, 4'b1100};
    vecs[2] = '{1'b1, 4'b0111, 4'b1110};
    vecs[3] = '{1'b1, 4'b1111, 4'b1111};
    vecs[4] = '{1'b1, 4'b1111, 4'b1111};
    vecs[5] = '{1'b0, 4'b1110, 4'b0111};
    vecs[6] = '{1'b1, 4'b1101, 4'b1011};
    vecs[7] = '{1'b1, 4'b1011, 4'b1101};

    din   = 1'b0;
    reset = 1'b0;
    #5 reset = 1'b1;
    #1;
    check("reset_4m", {4'b0, bus4m.dout}, 8'h00);
    check("reset_4l", {4'b0, bus4l.dout}, 8'h00);
    check("reset_8",  bus8.dout,          8'h00);

    // Release coincides with the 15 ns rising edge; that edge must not shift.
    @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("release_edge_4m", {4'b0, bus4m.dout}, 8'h00);
    check("no_x_8",          bus8.dout,          8'h00);
    check_all();

    for (int i = 0; i < 8; i++) begin
      drive_bit(vecs[i].din);
      check($sformatf("vec%0d_m", i), {4'b0, bus4m.dout}, {4'b0, vecs[i].exp_m});
      check($sformatf("vec%0d_l", i), {4'b0, bus4l.dout}, {4'b0, vecs[i].exp_l});
    end

    // Mid-word reset when dout = 0110, then four ones refill to 1111.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check("pre_reset_0110", {4'b0, bus4m.dout}, 8'h06);
    async_reset();
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1);
    end
    check("refill_1111", {4'b0, bus4m.dout}, 8'h0f);

    // 0xA5 MSB first into the 8-bit instance; also watch word_valid on the 4-bit one.
    async_reset();
    pat     = 8'hA5;
    wv_seen = '0;
    for (int i = 7; i >= 0; i--) begin
      drive_bit(pat[i]);
`ifdef SIPO_WORD_VALID_EN
      wv_seen[7-i] = bus4m.word_valid;
`endif
    end
    check("a5_width8", bus8.dout, 8'hA5);
`ifdef SIPO_WORD_VALID_EN
    check("wv_pattern_4", wv_seen, 8'b1000_1000);
`endif

    // Randomized stream with occasional asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        async_reset();
      end else begin
        drive_bit(1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
